transformation_sequencer: RTL and testbench
===========================================

# transformation_sequencer

Control FSM that sequences the GCN transformation datapath, which computes FM × WM one feature row at a time. It issues the weight-column and feature-row reads on the shared memory read port and pulses the per-column dot-product engine. It then emits one row-write strobe per feature row and signals completion to the top-level controller. It has no arithmetic datapath; it only holds counters and state.

## Interface
- FEATURE_ROWS, 6, feature-matrix rows (one output row each)
- WEIGHT_COLS, 3, weight-matrix columns (one dot product each)
- ADDRESS_WIDTH, 13, memory read-address width
- FEATURE_BASE, 13'h200, address of feature row 0; weight column c is at address c
- DP_TIMEOUT, 255, max cycles spent waiting for dp_valid
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS)
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  level request from top; sampled only in IDLE
- read_address  out  ADDRESS_WIDTH  memory read address
- enable_read  out  1  memory read strobe; data_in is valid in the same cycle (combinational memory)
- weight_load  out  1  datapath latches data_in into weight buffer column weight_col_sel
- weight_col_sel  out  COUNTER_WEIGHT_WIDTH  column index for weight_load and dp_start
- feature_load  out  1  datapath latches data_in as the current feature row
- dp_start  out  1  one-cycle pulse; starts the dot product of the feature row with column weight_col_sel
- dp_valid  in  1  dot-product result ready (one-cycle pulse)
- row_write  out  1  commit the assembled FM_WM row
- read_row  out  COUNTER_FEATURE_WIDTH  current feature-row index
- done_trans  out  1  all rows written
- error  out  1  dot-product timeout occurred

## Operation
- States: IDLE, LOAD_W, LOAD_F, COMPUTE, WAIT_DP, WRITE_ROW, DONE, ERROR. Counters: w_cnt, f_cnt, c_cnt, to_cnt.
- IDLE: all outputs 0. If start=1, go to LOAD_W with w_cnt=0 and f_cnt=0.
- LOAD_W: enable_read=1, read_address=w_cnt, weight_load=1, weight_col_sel=w_cnt.
  - If w_cnt=WEIGHT_COLS-1, go to LOAD_F.
  - Otherwise increment w_cnt.
- LOAD_F: enable_read=1, read_address=FEATURE_BASE+f_cnt, feature_load=1, read_row=f_cnt. Go to COMPUTE with c_cnt=0.
- COMPUTE: dp_start=1, weight_col_sel=c_cnt. Go to WAIT_DP with to_cnt=0.
- WAIT_DP: weight_col_sel=c_cnt.
  - On dp_valid: if c_cnt is last, go to WRITE_ROW; otherwise increment c_cnt and go to COMPUTE.
  - Without dp_valid: increment to_cnt. When to_cnt reaches DP_TIMEOUT-1, go to ERROR.
- WRITE_ROW: row_write=1, read_row=f_cnt.
  - If f_cnt is last, go to DONE.
  - Otherwise increment f_cnt and go to LOAD_F.
- DONE: done_trans=1, held while start=1. When start=0, go to IDLE.
- ERROR: error=1 and done_trans=0. The only exit is reset.
- Every output is decoded from registered state and counters only; there is no combinational path from any input to any output.
- read_address arithmetic is unsigned, zero-extended and truncated to ADDRESS_WIDTH. read_address=0 whenever enable_read=0.

## Timing
- Reset (reset=0 at an edge): state=IDLE, all counters 0, every output 0 from the next cycle. This applies from any state, including mid-row.
- Read latency is 0: data_in is consumed by the datapath at the same edge that ends the enable_read cycle.
- With dp_valid arriving L≥1 cycles after the dp_start cycle, WAIT_DP lasts L cycles.
- Cycles from the start-sampling edge to the first done_trans cycle: 1 + WEIGHT_COLS + FEATURE_ROWS·(2 + WEIGHT_COLS·(1+L)).
  - Defaults with L=1: 1+3+6·8 = 52. done_trans is first high in cycle 52 after start is sampled.
- dp_valid outside WAIT_DP is ignored.
- dp_valid on the same edge that to_cnt would time out counts as valid; there is no error.
- start toggling outside IDLE and DONE is ignored.
- If start=1 is held continuously, the block stays in DONE and never re-runs. A new run needs start to drop and rise again.

## Structure
- Package gcn_trans_pkg holds:
  - the state enum trans_state_t
  - FEATURE_BASE_DEFAULT = 13'h200
  - a localparam function for the timeout counter width, $clog2(DP_TIMEOUT+1)
- One sub-module, trans_ctrl_counter: parameterised width and terminal value, with clear, inc, and an is_last flag. It is instantiated for w_cnt, f_cnt and c_cnt.
- The FSM and output decode live in transformation_sequencer.

## Test plan
- Nominal run (defaults, L=1) -> read_address sequence 0,1,2,0x200; then 0x201 through 0x205 interleaved with compute. Exactly 18 dp_start pulses, 6 row_write pulses with read_row 0..5, done_trans in cycle 52.
- Variable latency (L randomly 1–10 per dot product) -> same address, dp_start and row_write ordering. done_trans cycle equals 4+6·2+(3·6)+ΣL.
- Timeout (dp_valid never arrives on row 2, column 1) -> error=1 exactly 255 cycles after entering WAIT_DP. done_trans stays 0, no further reads, and ERROR is held until reset.
- Reset mid-operation (reset=0 while in WAIT_DP on row 3) -> next cycle: all outputs 0, state IDLE. A fresh start produces the full nominal sequence from address 0.
- Spurious inputs (dp_valid pulses during LOAD_F and WRITE_ROW; start toggled during COMPUTE) -> no effect on the sequence or the cycle count.
- Handshake release (start held high after done_trans) -> remains in DONE. Dropping start returns to IDLE the next cycle; re-raising start begins a new run.

Source files
------------

// File: rtl/gcn_trans_pkg.sv
// Shared types and constants for the GCN transformation sequencer.
package gcn_trans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_F,
    COMPUTE,
    WAIT_DP,
    WRITE_ROW,
    DONE,
    ERROR
  } trans_state_t;

  localparam logic [12:0] FEATURE_BASE_DEFAULT = 13'h200;

  // Width needed to count 0..timeout inclusive.
  function automatic int timeout_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/transformation_sequencer_counter.sv
// Small clear/increment counter with a terminal-value flag.
module trans_ctrl_counter #(
  parameter int WIDTH = 2,
  parameter int LAST  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             is_last
);

  // Count register: reset/clear to zero, otherwise step on inc.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign is_last = (count == WIDTH'(LAST));

endmodule

// File: rtl/transformation_sequencer.sv
// Control FSM sequencing weight loads, feature-row loads, per-column dot
// products and row writes for the FM x WM transformation.
module transformation_sequencer
  import gcn_trans_pkg::*;
#(
  parameter int FEATURE_ROWS  = 6,
  parameter int WEIGHT_COLS   = 3,
  parameter int ADDRESS_WIDTH = 13,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = ADDRESS_WIDTH'(FEATURE_BASE_DEFAULT),
  parameter int DP_TIMEOUT    = 255,
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             enable_read,
  output logic                             weight_load,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_col_sel,
  output logic                             feature_load,
  output logic                             dp_start,
  input  logic                             dp_valid,
  output logic                             row_write,
  output logic [COUNTER_FEATURE_WIDTH-1:0] read_row,
  output logic                             done_trans,
  output logic                             error
);

  localparam int TO_W = timeout_width(DP_TIMEOUT);

  trans_state_t state, next_state;

  logic [COUNTER_WEIGHT_WIDTH-1:0]  w_cnt, c_cnt;
  logic [COUNTER_FEATURE_WIDTH-1:0] f_cnt;
  logic [TO_W-1:0]                  to_cnt;
  logic w_last, f_last, c_last, to_last;
  logic w_clear, w_inc, f_clear, f_inc, c_clear, c_inc;

  // Counter controls depend on state (and dp_valid for the column step);
  // they only feed registers, never outputs.
  assign w_clear = (state == IDLE);
  assign w_inc   = (state == LOAD_W) && !w_last;
  assign f_clear = (state == IDLE);
  assign f_inc   = (state == WRITE_ROW) && !f_last;
  assign c_clear = (state == LOAD_F);
  assign c_inc   = (state == WAIT_DP) && dp_valid && !c_last;
  assign to_last = (to_cnt == TO_W'(DP_TIMEOUT - 1));

  trans_ctrl_counter #(.WIDTH(COUNTER_WEIGHT_WIDTH), .LAST(WEIGHT_COLS - 1)) u_w_cnt (
    .clk(clk), .reset(reset), .clear(w_clear), .inc(w_inc), .count(w_cnt), .is_last(w_last)
  );

  trans_ctrl_counter #(.WIDTH(COUNTER_FEATURE_WIDTH), .LAST(FEATURE_ROWS - 1)) u_f_cnt (
    .clk(clk), .reset(reset), .clear(f_clear), .inc(f_inc), .count(f_cnt), .is_last(f_last)
  );

  trans_ctrl_counter #(.WIDTH(COUNTER_WEIGHT_WIDTH), .LAST(WEIGHT_COLS - 1)) u_c_cnt (
    .clk(clk), .reset(reset), .clear(c_clear), .inc(c_inc), .count(c_cnt), .is_last(c_last)
  );

  // Dot-product timeout counter: restarts with every dp_start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == COMPUTE) begin
      to_cnt <= '0;
    end else if ((state == WAIT_DP) && !dp_valid) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; outputs use only state and counters.
  always_comb begin
    next_state     = state;
    read_address   = '0;
    enable_read    = 1'b0;
    weight_load    = 1'b0;
    weight_col_sel = '0;
    feature_load   = 1'b0;
    dp_start       = 1'b0;
    row_write      = 1'b0;
    read_row       = '0;
    done_trans     = 1'b0;
    error          = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD_W;
      end
      LOAD_W: begin
        enable_read    = 1'b1;
        read_address   = ADDRESS_WIDTH'(w_cnt);
        weight_load    = 1'b1;
        weight_col_sel = w_cnt;
        if (w_last) next_state = LOAD_F;
      end
      LOAD_F: begin
        enable_read  = 1'b1;
        read_address = FEATURE_BASE + ADDRESS_WIDTH'(f_cnt);
        feature_load = 1'b1;
        read_row     = f_cnt;
        next_state   = COMPUTE;
      end
      COMPUTE: begin
        dp_start       = 1'b1;
        weight_col_sel = c_cnt;
        next_state     = WAIT_DP;
      end
      WAIT_DP: begin
        weight_col_sel = c_cnt;
        if (dp_valid) begin
          next_state = c_last ? WRITE_ROW : COMPUTE;
        end else if (to_last) begin
          next_state = ERROR;
        end
      end
      WRITE_ROW: begin
        row_write  = 1'b1;
        read_row   = f_cnt;
        next_state = f_last ? DONE : LOAD_F;
      end
      DONE: begin
        done_trans = 1'b1;
        if (!start) next_state = IDLE;
      end
      ERROR: begin
        error = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_transformation_sequencer.sv
// Bench for transformation_sequencer: event-level reference model of the
// expected read/compute/write ordering and the cycle-count formula.
module tb_transformation_sequencer;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int NDP  = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] read_address;
  logic        enable_read;
  logic        weight_load;
  logic [1:0]  weight_col_sel;
  logic        feature_load;
  logic        dp_start;
  logic        dp_valid;
  logic        row_write;
  logic [2:0]  read_row;
  logic        done_trans;
  logic        error;

  int tests = 0;
  int fails = 0;
  int lat[NDP];
  int exp_addr[$];
  int end_cyc;
  int lat_sum;

  transformation_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .read_address(read_address), .enable_read(enable_read),
    .weight_load(weight_load), .weight_col_sel(weight_col_sel),
    .feature_load(feature_load), .dp_start(dp_start), .dp_valid(dp_valid),
    .row_write(row_write), .read_row(read_row),
    .done_trans(done_trans), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, int'({read_address, enable_read, weight_load, weight_col_sel, feature_load,
                   dp_start, row_write, read_row, done_trans, error}), 0);
  endtask

  // mode: 0 nominal, 1 variable latency, 2 timeout on row 2 col 1,
  //       3 reset in WAIT_DP of row 3, 4 spurious dp_valid/start activity
  task automatic run_once(input int mode, output int fin_cyc);
    int  cd = 0, si = 0, row = 0, wl = 0, err_exp = -1, e;
    bit  fin = 0, rst_pend = 0;
    fin_cyc = -1;
    exp_addr.delete();
    for (int c = 0; c < COLS; c++) exp_addr.push_back(c);
    for (int r = 0; r < ROWS; r++) exp_addr.push_back('h200 + r);
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (rst_pend) begin
        reset = 1'b0;
        fin = 1;
        fin_cyc = cyc;
      end else begin
        dp_valid = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) dp_valid = 1'b1;
        end
        if (enable_read) begin
          e = (exp_addr.size() > 0) ? exp_addr.pop_front() : -1;
          chk("read_address", int'(read_address), e);
          if (wl < COLS) begin
            chk("weight_load", int'(weight_load), 1);
            chk("weight_sel", int'(weight_col_sel), wl);
            wl++;
          end else begin
            chk("feature_load", int'(feature_load), 1);
            chk("feature_row", int'(read_row), row);
          end
        end else begin
          chk("addr_idle", int'(read_address), 0);
        end
        if (dp_start) begin
          chk("dp_col", int'(weight_col_sel), si % COLS);
          cd = lat[si];
          if (mode == 2 && si == 7) begin
            cd = 0;
            err_exp = cyc + 256;
          end
          if (mode == 3 && si == 9) rst_pend = 1;
          if (mode == 4) start = ~start;
          si++;
        end
        if (row_write) begin
          chk("row_index", int'(read_row), row);
          row++;
          if (mode == 4) start = 1'b1;
        end
        if (mode == 4 && cd == 0 && (feature_load || row_write)) dp_valid = 1'b1;
        if (error) begin
          chk("error_cycle", cyc, err_exp);
          chk("done_at_error", int'(done_trans), 0);
          fin = 1;
          fin_cyc = cyc;
        end else if (done_trans) begin
          fin = 1;
          fin_cyc = cyc;
        end
      end
    end
    dp_valid = 1'b0;
    chk("bound_reached", int'(fin), 1);
    if (mode == 2) begin
      chk("reads_left", exp_addr.size(), 3);
    end else if (mode != 3) begin
      chk("dp_count", si, NDP);
      chk("row_count", row, ROWS);
      chk("reads_left", exp_addr.size(), 0);
    end
  endtask

  task automatic release_done();
    start = 1'b0;
    @(negedge clk);
    chk_idle("idle_after_release");
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    dp_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset_state");
    reset = 1'b1;
    @(negedge clk);
    chk_idle("idle_no_start");

    // Nominal run, L=1, then hold start in DONE.
    for (int i = 0; i < NDP; i++) lat[i] = 1;
    run_once(0, end_cyc);
    chk("nominal_done_cycle", end_cyc, 52);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("done_held", int'(done_trans), 1);
    end
    release_done();

    // Variable latency, one dot product at the exact timeout boundary.
    lat_sum = 0;
    for (int i = 0; i < NDP; i++) lat[i] = int'($urandom_range(1, 10));
    lat[5] = 255;
    for (int i = 0; i < NDP; i++) lat_sum += lat[i];
    run_once(1, end_cyc);
    chk("varlat_done_cycle", end_cyc, 4 + ROWS * 2 + COLS * ROWS + lat_sum);
    chk("varlat_no_error", int'(error), 0);
    release_done();

    // Spurious dp_valid and start activity.
    for (int i = 0; i < NDP; i++) lat[i] = 1;
    run_once(4, end_cyc);
    chk("spurious_done_cycle", end_cyc, 52);
    release_done();

    // Reset while waiting on a dot product in row 3.
    run_once(3, end_cyc);
    @(negedge clk);
    chk_idle("mid_reset_outputs");
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk_idle("after_mid_reset");
    run_once(0, end_cyc);
    chk("rerun_done_cycle", end_cyc, 52);
    release_done();

    // Timeout on row 2, column 1.
    run_once(2, end_cyc);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("error_held", int'(error), 1);
      chk("no_read_in_error", int'(enable_read), 0);
      chk("no_done_in_error", int'(done_trans), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset_from_error");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
